// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the IDCT transpose buffer: bank states and block geometry.
package aq_djpeg_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bankStateT;

  localparam int unsigned BLOCK_LAST_ADDR = 31;
  localparam int unsigned LAST_PAGE       = 7;
  localparam int unsigned LAST_COUNT      = 3;
  localparam int unsigned BLOCK_CELLS     = 64;

endpackage

// File: rtl/aq_djpeg_idct_xpose_if.sv
// Row-pass write port, column-pass read port and status flags of the transpose buffer.
interface aq_djpeg_idct_xpose_if #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16
);
  logic              DataInit;
  logic              DataInEnable;
  logic [2:0]        DataInPage;
  logic [1:0]        DataInCount;
  logic [IN_W-1:0]   DataInA;
  logic [IN_W-1:0]   DataInB;
  logic              DataInIdle;
  logic              DataOutEnable;
  logic              DataOutRead;
  logic [4:0]        DataOutAddress;
  logic [OUT_W-1:0]  DataOutA;
  logic [OUT_W-1:0]  DataOutB;
  logic              Overflow;
  logic              SatFlag;

  modport master (
    output DataInit, DataInEnable, DataInPage, DataInCount, DataInA, DataInB,
    output DataOutRead, DataOutAddress,
    input  DataInIdle, DataOutEnable, DataOutA, DataOutB, Overflow, SatFlag
  );

  modport slave (
    input  DataInit, DataInEnable, DataInPage, DataInCount, DataInA, DataInB,
    input  DataOutRead, DataOutAddress,
    output DataInIdle, DataOutEnable, DataOutA, DataOutB, Overflow, SatFlag
  );
endinterface

// File: rtl/aq_djpeg_idct_rndsat.sv
// Combinational fixed-point scaling: optional round-half-up, arithmetic shift, optional clamp.
module aq_djpeg_idct_rndsat #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned LSB   = 11,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned ROUND = 1,
  parameter int unsigned SAT   = 1
) (
  input  logic [IN_W-1:0]  dataIn,
  output logic [OUT_W-1:0] dataOut,
  output logic             sat
);
  localparam int unsigned EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] RND  = (ROUND != 0) ? (EXT_W'(1) <<< (LSB - 1)) : '0;
  localparam logic signed [EXT_W-1:0] MAXV = EXT_W'({(OUT_W-1){1'b1}});
  localparam logic signed [EXT_W-1:0] MINV = ~MAXV;

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] shifted;

  // One extra bit keeps the rounding add from overflowing at the top of the range.
  always_comb begin
    ext     = {dataIn[IN_W-1], dataIn};
    sum     = ext + RND;
    shifted = sum >>> LSB;
    sat     = 1'b0;
    dataOut = shifted[OUT_W-1:0];
    if (SAT != 0) begin
      if (shifted > MAXV) begin
        dataOut = MAXV[OUT_W-1:0];
        sat     = 1'b1;
      end else if (shifted < MINV) begin
        dataOut = MINV[OUT_W-1:0];
        sat     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/aq_djpeg_idct_xpose.sv
// Multi-bank 8x8 transpose buffer between IDCT row and column passes.
module aq_djpeg_idct_xpose
  import aq_djpeg_pkg::*;
#(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned LSB       = 11,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned ROUND     = 1,
  parameter int unsigned SAT       = 1,
  parameter int unsigned NUM_BANKS = 2
) (
  input logic clk,
  input logic rst,
  aq_djpeg_idct_xpose_if.slave bus
);
  localparam int unsigned BANK_W = (NUM_BANKS > 2) ? 2 : 1;

  typedef logic [BANK_W-1:0] bankIdxT;

  function automatic bankIdxT nextBank(input bankIdxT p);
    return (32'(p) == NUM_BANKS - 1) ? '0 : BANK_W'(p + 1'b1);
  endfunction

  bankStateT         bankState    [NUM_BANKS];
  bankStateT         bankStateNxt [NUM_BANKS];
  bankIdxT           wp, wpNxt, rp, rpNxt;
  logic              writable, readable, wrOk, rdOk, wrLast, rdLast;
  logic [OUT_W-1:0]  sA, sB;
  logic              satA, satB;
  logic [OUT_W-1:0]  mem [NUM_BANKS][BLOCK_CELLS];

  aq_djpeg_idct_rndsat #(.IN_W(IN_W), .LSB(LSB), .OUT_W(OUT_W), .ROUND(ROUND), .SAT(SAT))
    u_rsA (.dataIn(bus.DataInA), .dataOut(sA), .sat(satA));

  aq_djpeg_idct_rndsat #(.IN_W(IN_W), .LSB(LSB), .OUT_W(OUT_W), .ROUND(ROUND), .SAT(SAT))
    u_rsB (.dataIn(bus.DataInB), .dataOut(sB), .sat(satB));

  // Bank state and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) bankState[i] <= BANK_EMPTY;
      wp <= '0;
      rp <= '0;
    end else if (bus.DataInit) begin
      for (int i = 0; i < NUM_BANKS; i++) bankState[i] <= BANK_EMPTY;
      wp <= '0;
      rp <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) bankState[i] <= bankStateNxt[i];
      wp <= wpNxt;
      rp <= rpNxt;
    end
  end

  // Next state: wp and rp never address the same bank when both a write and a read are legal.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) bankStateNxt[i] = bankState[i];
    wpNxt = wp;
    rpNxt = rp;
    if (wrOk) begin
      bankStateNxt[wp] = wrLast ? BANK_FULL : BANK_FILLING;
      if (wrLast) wpNxt = nextBank(wp);
    end
    if (rdOk) begin
      bankStateNxt[rp] = rdLast ? BANK_EMPTY : BANK_READING;
      if (rdLast) rpNxt = nextBank(rp);
    end
  end

  // Handshake decode from the current state
  always_comb begin
    writable          = (bankState[wp] == BANK_EMPTY) || (bankState[wp] == BANK_FILLING);
    readable          = (bankState[rp] == BANK_FULL)  || (bankState[rp] == BANK_READING);
    wrOk              = bus.DataInEnable && writable;
    rdOk              = bus.DataOutRead && readable;
    wrLast            = (bus.DataInPage == 3'(LAST_PAGE)) && (bus.DataInCount == 2'(LAST_COUNT));
    rdLast            = bus.DataOutAddress == 5'(BLOCK_LAST_ADDR);
    bus.DataInIdle    = writable;
    bus.DataOutEnable = readable;
  end

  // Cell index is row*8+col; B lands in column 7-Count, i.e. {1, ~Count}.
  always_ff @(posedge clk) begin
    if (wrOk) begin
      mem[wp][{bus.DataInPage, 1'b0, bus.DataInCount}]  <= sA;
      mem[wp][{bus.DataInPage, 1'b1, ~bus.DataInCount}] <= sB;
    end
  end

  // Transposed read data and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.DataOutA <= '0;
      bus.DataOutB <= '0;
      bus.Overflow <= 1'b0;
      bus.SatFlag  <= 1'b0;
    end else if (bus.DataInit) begin
      bus.DataOutA <= '0;
      bus.DataOutB <= '0;
      bus.Overflow <= 1'b0;
      bus.SatFlag  <= 1'b0;
    end else begin
      if (bus.DataInEnable && !writable) bus.Overflow <= 1'b1;
      if (wrOk && (satA || satB))        bus.SatFlag  <= 1'b1;
      if (rdOk) begin
        bus.DataOutA <= mem[rp][{1'b0, bus.DataOutAddress[1:0], bus.DataOutAddress[4:2]}];
        bus.DataOutB <= mem[rp][{1'b1, bus.DataOutAddress[1:0], bus.DataOutAddress[4:2]}];
      end
    end
  end
endmodule

// File: tb/tb_aq_djpeg_idct_xpose.sv
// Directed bench for the transpose buffer: default build plus a truncate/wrap build on shared inputs.
module tb_aq_djpeg_idct_xpose;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [31:0] din;
    logic [15:0] expRs;
    logic [15:0] expRaw;
  } vecT;

  vecT vecs [10];

  aq_djpeg_idct_xpose_if #(.IN_W(32), .OUT_W(16)) bus ();
  aq_djpeg_idct_xpose_if #(.IN_W(32), .OUT_W(16)) bus2 ();

  aq_djpeg_idct_xpose #(.IN_W(32), .LSB(11), .OUT_W(16), .ROUND(1), .SAT(1), .NUM_BANKS(2))
    dut (.clk(clk), .rst(rst), .bus(bus));

  aq_djpeg_idct_xpose #(.IN_W(32), .LSB(11), .OUT_W(16), .ROUND(0), .SAT(0), .NUM_BANKS(2))
    dutRaw (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.DataInit       = bus.DataInit;
  assign bus2.DataInEnable   = bus.DataInEnable;
  assign bus2.DataInPage     = bus.DataInPage;
  assign bus2.DataInCount    = bus.DataInCount;
  assign bus2.DataInA        = bus.DataInA;
  assign bus2.DataInB        = bus.DataInB;
  assign bus2.DataOutRead    = bus.DataOutRead;
  assign bus2.DataOutAddress = bus.DataOutAddress;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic writePair(input logic [2:0] p, input logic [1:0] c,
                           input logic [31:0] a, input logic [31:0] b);
    bus.DataInEnable = 1'b1;
    bus.DataInPage   = p;
    bus.DataInCount  = c;
    bus.DataInA      = a;
    bus.DataInB      = b;
    @(negedge clk);
    bus.DataInEnable = 1'b0;
  endtask

  task automatic writeBlock(input int tag);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        writePair(3'(r), 2'(c), 32'((tag * 64 + r * 8 + c) << 11),
                  32'((tag * 64 + r * 8 + 7 - c) << 11));
  endtask

  task automatic readAddr(input logic [4:0] addr, output logic [15:0] a, output logic [15:0] b,
                          output logic [15:0] a2);
    bus.DataOutRead    = 1'b1;
    bus.DataOutAddress = addr;
    @(negedge clk);
    bus.DataOutRead = 1'b0;
    a  = bus.DataOutA;
    b  = bus.DataOutB;
    a2 = bus2.DataOutA;
  endtask

  task automatic readBlock(input int tag, input string name);
    logic [15:0] a, b, a2;
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 4; k++) begin
        readAddr({3'(c), 2'(k)}, a, b, a2);
        check({name, "_A"}, 32'(a), 32'(16'(tag * 64 + k * 8 + c)));
        check({name, "_B"}, 32'(b), 32'(16'(tag * 64 + (k + 4) * 8 + c)));
      end
  endtask

  initial begin
    logic [15:0] a, b, a2;

    vecs[0] = '{32'h0000_03FF, 16'h0000, 16'h0000};
    vecs[1] = '{32'h0000_0400, 16'h0001, 16'h0000};
    vecs[2] = '{32'hFFFF_FC00, 16'h0000, 16'hFFFF};
    vecs[3] = '{32'hFFFF_FBFF, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{32'h7FFF_FFFF, 16'h7FFF, 16'hFFFF};
    vecs[5] = '{32'h8000_0000, 16'h8000, 16'h0000};
    vecs[6] = '{32'h0012_3456, 16'h0247, 16'h0246};
    vecs[7] = '{32'hFFF0_0000, 16'hFE00, 16'hFE00};
    vecs[8] = '{32'h03FF_FBFF, 16'h7FFF, 16'h7FFF};
    vecs[9] = '{32'h03FF_FC00, 16'h7FFF, 16'h7FFF};

    bus.DataInit = 1'b0;
    bus.DataInEnable = 1'b0;
    bus.DataInPage = '0;
    bus.DataInCount = '0;
    bus.DataInA = '0;
    bus.DataInB = '0;
    bus.DataOutRead = 1'b0;
    bus.DataOutAddress = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_idle", 32'(bus.DataInIdle), 32'd1);
    check("rst_oen", 32'(bus.DataOutEnable), 32'd0);
    check("rst_outA", 32'(bus.DataOutA), 32'd0);
    check("rst_ovf", 32'(bus.Overflow), 32'd0);
    check("rst_sat", 32'(bus.SatFlag), 32'd0);
    readAddr(5'd9, a, b, a2);
    check("rd_empty_hold", 32'(a), 32'd0);

    // Ramp block, read back transposed
    writeBlock(0);
    check("ramp_oen", 32'(bus.DataOutEnable), 32'd1);
    check("ramp_idle", 32'(bus.DataInIdle), 32'd1);
    readBlock(0, "ramp");
    check("ramp_oen_drop", 32'(bus.DataOutEnable), 32'd0);
    readAddr(5'd0, a, b, a2);
    check("ramp_holdA", 32'(a), 32'd31);
    check("ramp_holdB", 32'(b), 32'd63);
    check("ramp_sat", 32'(bus.SatFlag), 32'd0);

    // Conversion table: vector i at row i/4, column i%4
    for (int i = 0; i < 32; i++)
      writePair(3'(i >> 2), 2'(i & 3), (i < 10) ? vecs[i].din : 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      readAddr({3'(i & 3), 2'(i >> 2)}, a, b, a2);
      check($sformatf("vec%0d_rs", i), 32'(a), 32'(vecs[i].expRs));
      check($sformatf("vec%0d_raw", i), 32'(a2), 32'(vecs[i].expRaw));
    end
    check("vec_satflag", 32'(bus.SatFlag), 32'd1);
    check("vec_satflag_raw", 32'(bus2.SatFlag), 32'd0);
    readAddr(5'd31, a, b, a2);
    check("vec_release", 32'(bus.DataOutEnable), 32'd0);

    // Back-pressure: two blocks fill both banks, third is dropped
    writeBlock(1);
    writeBlock(2);
    check("bp_idle0", 32'(bus.DataInIdle), 32'd0);
    check("bp_ovf0", 32'(bus.Overflow), 32'd0);
    writeBlock(3);
    check("bp_ovf1", 32'(bus.Overflow), 32'd1);
    check("bp_idle_still0", 32'(bus.DataInIdle), 32'd0);
    readBlock(1, "bp_blk1");
    check("bp_idle_freed", 32'(bus.DataInIdle), 32'd1);
    readBlock(2, "bp_blk2");

    // DataInit clears sticky flags and read data
    bus.DataInit = 1'b1;
    @(negedge clk);
    bus.DataInit = 1'b0;
    check("init_ovf", 32'(bus.Overflow), 32'd0);
    check("init_sat", 32'(bus.SatFlag), 32'd0);
    check("init_outB", 32'(bus.DataOutB), 32'd0);
    check("init_idle", 32'(bus.DataInIdle), 32'd1);

    // Concurrent write of block 2 while block 1 drains
    writeBlock(1);
    fork
      writeBlock(2);
      readBlock(1, "conc_rd1");
    join
    readBlock(2, "conc_rd2");
    check("conc_ovf", 32'(bus.Overflow), 32'd0);

    // Async reset in the middle of a read
    writeBlock(3);
    readAddr(5'd0, a, b, a2);
    readAddr(5'd1, a, b, a2);
    check("pre_rst_A", 32'(a), 32'(16'(3 * 64 + 8)));
    #2 rst = 1'b1;
    #1;
    check("arst_outA", 32'(bus.DataOutA), 32'd0);
    check("arst_outB", 32'(bus.DataOutB), 32'd0);
    check("arst_oen", 32'(bus.DataOutEnable), 32'd0);
    check("arst_idle", 32'(bus.DataInIdle), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // DataInit mid-block: next block must land in bank 0
    writeBlock(4);
    for (int i = 0; i < 5; i++) writePair(3'(i >> 2), 2'(i & 3), 32'h0001_0000, 32'h0001_0000);
    bus.DataInit = 1'b1;
    @(negedge clk);
    bus.DataInit = 1'b0;
    check("dinit_oen", 32'(bus.DataOutEnable), 32'd0);
    check("dinit_idle", 32'(bus.DataInIdle), 32'd1);
    writeBlock(5);
    readBlock(5, "dinit_rd");
    check("dinit_ovf", 32'(bus.Overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
